ahb_rr_arbiter: RTL



---
 rtl/ahb_rr_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ahb_rr_arbiter.sv
// AHB-Lite bus arbiter for up to 4 masters: round-robin grant, with fixed bursts and locked transfers held.
// Define ARB_FIXED_PRIORITY_EN to replace round-robin with lowest-index-wins priority.
module ahb_rr_arbiter #(
   parameter int NUM_MASTERS    = 4,
   parameter int DEFAULT_MASTER = 0
) (
   input  logic                   hclk,
   input  logic                   hresetn,
   input  logic [NUM_MASTERS-1:0] hbusreq,
   input  logic [NUM_MASTERS-1:0] hlock,
   input  logic                   hready,
   input  logic [1:0]             htrans,
   input  logic [2:0]             hburst,
   output logic [NUM_MASTERS-1:0] hgrant,
   output logic [1:0]             hmaster,
   output logic                   hmastlock
);

   typedef enum logic [1:0] {PARK, GRANTED, BURST, LOCKED} state_t;

   localparam logic [1:0] DEF_IDX   = 2'(DEFAULT_MASTER);
   localparam logic [1:0] TR_IDLE   = 2'd0;
   localparam logic [1:0] TR_NONSEQ = 2'd2;
   localparam logic [1:0] TR_SEQ    = 2'd3;

   state_t     state, state_n;
   logic [1:0] grant_idx, grant_n;
   logic [1:0] last_owner, last_n;
   logic [3:0] count, count_n;
   logic [3:0] burst_len;
   logic [1:0] winner;
   logic       any_req;
   logic       owner_lock;
   logic       arbitrate;

   always_comb begin
      hgrant = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         hgrant[i] = (grant_idx == 2'(i));
      end
   end

   assign owner_lock = hlock[grant_idx] & hbusreq[grant_idx];
   assign any_req    = |hbusreq;

   always_comb begin
      burst_len = 4'd0;
      case (hburst)
         3'd2, 3'd3: burst_len = 4'd3;
         3'd4, 3'd5: burst_len = 4'd7;
         3'd6, 3'd7: burst_len = 4'd15;
         default:    burst_len = 4'd0;
      endcase
   end

   // Candidates are scanned farthest-first so the nearest requester overwrites the result.
   always_comb begin
      winner = DEF_IDX;
`ifdef ARB_FIXED_PRIORITY_EN
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         if (hbusreq[i]) winner = 2'(i);
      end
`else
      for (int i = NUM_MASTERS; i >= 1; i--) begin
         if (hbusreq[(int'(last_owner) + i) % NUM_MASTERS])
            winner = 2'((int'(last_owner) + i) % NUM_MASTERS);
      end
`endif
   end

   always_comb begin
      state_n   = state;
      grant_n   = grant_idx;
      last_n    = last_owner;
      count_n   = count;
      arbitrate = 1'b0;
      case (state)
         PARK:    arbitrate = any_req;
         GRANTED: begin
            if (owner_lock) begin
               state_n = LOCKED;
            end else if (htrans == TR_NONSEQ && burst_len != 4'd0) begin
               count_n = burst_len;
               state_n = BURST;
            end else begin
               arbitrate = 1'b1;
            end
         end
         BURST: begin
            if (htrans == TR_IDLE) begin
               count_n = 4'd0;
               state_n = GRANTED;
            end else if (htrans == TR_SEQ) begin
               // Releasing on the final SEQ lets the next owner's address phase overlap the last beat.
               if (count <= 4'd1) begin
                  count_n   = 4'd0;
                  arbitrate = 1'b1;
               end else begin
                  count_n = count - 4'd1;
               end
            end
         end
         LOCKED:  arbitrate = !owner_lock;
         default: state_n = PARK;
      endcase
      if (arbitrate) begin
         if (any_req) begin
            grant_n = winner;
            last_n  = winner;
            state_n = GRANTED;
         end else begin
            grant_n = DEF_IDX;
            state_n = PARK;
         end
      end
   end

   always_ff @(posedge hclk) begin
      if (!hresetn) begin
         state      <= PARK;
         grant_idx  <= DEF_IDX;
         last_owner <= DEF_IDX;
         count      <= 4'd0;
         hmaster    <= DEF_IDX;
         hmastlock  <= 1'b0;
      end else if (hready) begin
         state      <= state_n;
         grant_idx  <= grant_n;
         last_owner <= last_n;
         count      <= count_n;
         hmaster    <= grant_idx;
         hmastlock  <= owner_lock;
      end
   end

endmodule
